// File: rtl/instr_fetch_latch_pkg.sv
// Shared definitions for the instruction fetch latch: state encoding,
// instruction field positions and the default fetch timeout.
package instr_fetch_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    VALID = 2'b10
  } ifl_state_e;

  localparam int OPC_HI      = 15;
  localparam int REG_HI      = 11;
  localparam int IMM4_HI     = 3;
  localparam int IMM8_HI     = 7;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/instr_fetch_latch_if.sv
// Fetch/memory/decode handshake bundle for the instruction fetch latch.
interface instr_fetch_latch_if;
  logic        fetch_req;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        consume;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  reg_sel;
  logic [3:0]  imm4;
  logic [7:0]  imm8;
  logic        ir_valid;
  logic        busy;
  logic        timeout_err;

  modport master (
    output fetch_req, mem_data, mem_ready, consume,
    input  ir, opcode, reg_sel, imm4, imm8, ir_valid, busy, timeout_err
  );

  modport slave (
    input  fetch_req, mem_data, mem_ready, consume,
    output ir, opcode, reg_sel, imm4, imm8, ir_valid, busy, timeout_err
  );
endinterface

// File: rtl/instr_fetch_latch_wait_timer.sv
// Wait-cycle counter for an outstanding fetch; expired marks the last
// allowed wait cycle (count == TIMEOUT-1).
module wait_timer
  import instr_fetch_latch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/instr_fetch_latch.sv
// Instruction fetch latch: requests a word, waits for memory with a timeout,
// and holds it in ir until the decode stage consumes it.
module instr_fetch_latch
  import instr_fetch_latch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_latch_if.slave   bus
);

  ifl_state_e  r_state;
  logic [15:0] r_ir;
  logic        r_ir_valid;
  logic        r_busy;
  logic        r_timeout_err;

  logic w_start;
  logic w_tmr_en;
  logic w_expired;

  // A new fetch starts from IDLE, or straight from VALID when the word is consumed.
  assign w_start  = bus.fetch_req &&
                    ((r_state == IDLE) || ((r_state == VALID) && bus.consume));
  // Hold the count at the limit so it can never run past TIMEOUT-1.
  assign w_tmr_en = (r_state == WAIT) && !bus.mem_ready && !w_expired;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_start),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ir          <= 16'h0000;
      r_ir_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.fetch_req) begin
            r_state       <= WAIT;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
          end
        end
        WAIT: begin
          // Capture wins over timeout on the final wait cycle.
          if (bus.mem_ready) begin
            r_ir       <= bus.mem_data;
            r_state    <= VALID;
            r_ir_valid <= 1'b1;
            r_busy     <= 1'b0;
          end else if (w_expired) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end
        end
        VALID: begin
          if (bus.consume) begin
            r_ir_valid <= 1'b0;
            if (bus.fetch_req) begin
              r_state       <= WAIT;
              r_busy        <= 1'b1;
              r_timeout_err <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ir_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ir          = r_ir;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.opcode      = r_ir[OPC_HI  -: 4];
  assign bus.reg_sel     = r_ir[REG_HI  -: 4];
  assign bus.imm4        = r_ir[IMM4_HI -: 4];
  assign bus.imm8        = r_ir[IMM8_HI -: 8];

endmodule

// File: tb/tb_instr_fetch_latch.sv
// Directed bench for instr_fetch_latch with TIMEOUT=15.
module tb_instr_fetch_latch;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_latch_if bus ();

  instr_fetch_latch #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.fetch_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.consume   = 1'b0;
    bus.mem_data  = 16'h0000;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_valid", 16'(bus.ir_valid), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_terr", 16'(bus.timeout_err), 16'h0);

    // mem_ready and consume in IDLE are ignored
    bus.mem_ready = 1'b1; bus.mem_data = 16'hDEAD; bus.consume = 1'b1;
    step();
    idle_inputs();
    chk("idle_mr_ir", bus.ir, 16'h0000);
    chk("idle_mr_valid", 16'(bus.ir_valid), 16'h0);
    chk("idle_busy", 16'(bus.busy), 16'h0);

    // basic fetch, mem_ready two cycles later
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    chk("f1_busy", 16'(bus.busy), 16'h1);
    step();
    step();
    bus.mem_ready = 1'b1; bus.mem_data = 16'h3A5C;
    chk("f1_prevalid", 16'(bus.ir_valid), 16'h0);
    step();
    idle_inputs();
    chk("f1_ir", bus.ir, 16'h3A5C);
    chk("f1_opcode", 16'(bus.opcode), 16'h3);
    chk("f1_regsel", 16'(bus.reg_sel), 16'hA);
    chk("f1_imm4", 16'(bus.imm4), 16'hC);
    chk("f1_imm8", 16'(bus.imm8), 16'h5C);
    chk("f1_valid", 16'(bus.ir_valid), 16'h1);
    chk("f1_busy_done", 16'(bus.busy), 16'h0);

    // VALID ignores fetch_req and mem_ready without consume
    bus.fetch_req = 1'b1; bus.mem_ready = 1'b1; bus.mem_data = 16'hFFFF;
    step();
    idle_inputs();
    chk("hold_ir", bus.ir, 16'h3A5C);
    chk("hold_valid", 16'(bus.ir_valid), 16'h1);
    chk("hold_busy", 16'(bus.busy), 16'h0);

    // consume drops ir_valid but ir is retained
    bus.consume = 1'b1;
    step();
    idle_inputs();
    chk("cons_valid", 16'(bus.ir_valid), 16'h0);
    chk("cons_ir", bus.ir, 16'h3A5C);

    // timeout: busy for exactly 15 cycles
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
    chk("to_busy_cycles", 16'(n), 16'd15);
    chk("to_terr", 16'(bus.timeout_err), 16'h1);
    chk("to_ir", bus.ir, 16'h3A5C);
    chk("to_valid", 16'(bus.ir_valid), 16'h0);
    step();
    chk("to_idle_busy", 16'(bus.busy), 16'h0);

    // next fetch clears timeout_err; capture exactly on the final wait cycle
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    chk("clr_terr", 16'(bus.timeout_err), 16'h0);
    repeat (14) step();
    chk("edge_busy", 16'(bus.busy), 16'h1);
    bus.mem_ready = 1'b1; bus.mem_data = 16'h1234;
    step();
    idle_inputs();
    chk("edge_ir", bus.ir, 16'h1234);
    chk("edge_valid", 16'(bus.ir_valid), 16'h1);
    chk("edge_terr", 16'(bus.timeout_err), 16'h0);

    // back-to-back: consume+fetch together, data one cycle later
    bus.consume = 1'b1; bus.fetch_req = 1'b1;
    step();
    idle_inputs();
    chk("b2b_gap_valid", 16'(bus.ir_valid), 16'h0);
    chk("b2b_gap_busy", 16'(bus.busy), 16'h1);
    chk("b2b_gap_ir", bus.ir, 16'h1234);
    bus.mem_ready = 1'b1; bus.mem_data = 16'hF00F;
    step();
    idle_inputs();
    chk("b2b_valid", 16'(bus.ir_valid), 16'h1);
    chk("b2b_ir", bus.ir, 16'hF00F);

    // reset during WAIT discards a coincident mem_ready
    bus.consume = 1'b1; bus.fetch_req = 1'b1;
    step();
    idle_inputs();
    step();
    chk("rw_pre_busy", 16'(bus.busy), 16'h1);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.mem_data = 16'hBEEF;
    step();
    reset = 1'b0;
    idle_inputs();
    chk("rw_ir", bus.ir, 16'h0000);
    chk("rw_valid", 16'(bus.ir_valid), 16'h0);
    chk("rw_busy", 16'(bus.busy), 16'h0);
    bus.mem_ready = 1'b1; bus.mem_data = 16'hBEEF;
    step();
    idle_inputs();
    chk("rw_after_ir", bus.ir, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
